// File: rtl/coeffs_writer.sv
// Coefficient-load master: fetches one band's taps from a synchronous ROM and
// streams them into a band filter, then holds write_done for the filter's capture window.
module coeffs_writer #(
    parameter int NUM_TAPS  = 64,
    parameter int ADDR_W    = 6,
    parameter int COEFF_W   = 16,
    parameter int BAND_W    = 3,
    parameter int DONE_HOLD = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_enable,
    input  logic                       i_start,
    input  logic [BAND_W-1:0]          i_band_sel,
    output logic [BAND_W+ADDR_W-1:0]   o_rom_addr,
    input  logic signed [COEFF_W-1:0]  i_rom_data,
    output logic                       o_write_enable,
    output logic [ADDR_W-1:0]          o_write_address,
    output logic signed [COEFF_W-1:0]  o_coeffs_in,
    output logic                       o_write_done,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int HOLD_W = $clog2(DONE_HOLD + 1);
    localparam logic [ADDR_W:0]   WR_END    = (ADDR_W + 1)'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] TAP_MAX   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_HOLD, S_FIN} state_e;

    state_e                      state_q, state_d;
    logic [BAND_W-1:0]           band_q, band_d;
    logic [ADDR_W-1:0]           tap_q, tap_d;
    logic [ADDR_W:0]             wr_cnt_q, wr_cnt_d;
    logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
    logic                        we_q, we_d;
    logic [ADDR_W-1:0]           waddr_q, waddr_d;
    logic signed [COEFF_W-1:0]   coeffs_q, coeffs_d;
    logic                        wdone_q, wdone_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a latch behind.
        state_d    = state_q;
        band_d     = band_q;
        tap_d      = tap_q;
        wr_cnt_d   = wr_cnt_q;
        hold_cnt_d = hold_cnt_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        coeffs_d   = coeffs_q;
        wdone_d    = wdone_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    band_d     = i_band_sel;
                    tap_d      = '0;
                    wr_cnt_d   = '0;
                    hold_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                tap_d   = tap_q + ADDR_W'(1);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // ROM data lags the address by one cycle, so the write counter trails the tap.
                if (wr_cnt_q < WR_END) begin
                    we_d     = 1'b1;
                    coeffs_d = i_rom_data;
                    waddr_d  = wr_cnt_q[ADDR_W-1:0];
                    wr_cnt_d = wr_cnt_q + (ADDR_W + 1)'(1);
                    if (tap_q != TAP_MAX) tap_d = tap_q + ADDR_W'(1);
                end else begin
                    we_d       = 1'b0;
                    waddr_d    = '0;
                    coeffs_d   = '0;
                    wdone_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    wdone_d = 1'b0;
                    state_d = S_FIN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; clk_enable freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            band_q     <= '0;
            tap_q      <= '0;
            wr_cnt_q   <= '0;
            hold_cnt_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            coeffs_q   <= '0;
            wdone_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (clk_enable) begin
            state_q    <= state_d;
            band_q     <= band_d;
            tap_q      <= tap_d;
            wr_cnt_q   <= wr_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            coeffs_q   <= coeffs_d;
            wdone_q    <= wdone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_rom_addr      = {band_q, tap_q};
    assign o_write_enable  = we_q;
    assign o_write_address = waddr_q;
    assign o_coeffs_in     = coeffs_q;
    assign o_write_done    = wdone_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_coeffs_writer.sv
// Bench for coeffs_writer: a timeline model indexed by enabled cycles since start
// predicts every output; a behavioural ROM answers {band,tap}+0x100.
module tb_coeffs_writer;

    localparam int LAT  = 2 + 64 + 64 + 1;   // enabled cycles from start to o_done
    localparam int IDLE_N = LAT + 1;

    typedef struct packed {
        logic [8:0]  rom_addr;
        logic        we;
        logic [5:0]  waddr;
        logic [15:0] coeffs;
        logic        wd;
        logic        busy;
        logic        done;
    } outs_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_enable;
    logic               i_start;
    logic [2:0]         i_band_sel;
    logic [8:0]         o_rom_addr;
    logic signed [15:0] i_rom_data;
    logic               o_write_enable;
    logic [5:0]         o_write_address;
    logic signed [15:0] o_coeffs_in;
    logic               o_write_done;
    logic               o_busy;
    logic               o_done;

    int vectors = 0;
    int miscompares = 0;

    coeffs_writer dut (
        .clk             (clk),
        .rst             (rst),
        .clk_enable      (clk_enable),
        .i_start         (i_start),
        .i_band_sel      (i_band_sel),
        .o_rom_addr      (o_rom_addr),
        .i_rom_data      (i_rom_data),
        .o_write_enable  (o_write_enable),
        .o_write_address (o_write_address),
        .o_coeffs_in     (o_coeffs_in),
        .o_write_done    (o_write_done),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(int band, int tap);
        return 16'(band * 64 + tap + 256);
    endfunction

    // Synchronous ROM sharing the DUT's clock enable.
    always @(posedge clk) begin
        if (clk_enable) i_rom_data <= rom_word(int'(o_rom_addr[8:6]), int'(o_rom_addr[5:0]));
    end

    // Expected outputs n enabled cycles after the accepted start edge (n<0: fresh from reset).
    function automatic outs_t model(int n, int band);
        outs_t o = '0;
        int tap;
        if (n < 0) return o;
        tap        = (n < 63) ? n : 63;
        o.rom_addr = 9'(band * 64 + tap);
        o.busy     = (n <= LAT - 1);
        o.we       = (n >= 2 && n <= 65);
        if (o.we) begin
            o.waddr  = 6'(n - 2);
            o.coeffs = rom_word(band, n - 2);
        end
        o.wd   = (n >= 66 && n <= 129);
        o.done = (n == LAT);
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t o;
        o.rom_addr = o_rom_addr;
        o.we       = o_write_enable;
        o.waddr    = o_write_address;
        o.coeffs   = o_coeffs_in;
        o.wd       = o_write_done;
        o.busy     = o_busy;
        o.done     = o_done;
        return o;
    endfunction

    task automatic cycle(input logic en);
        clk_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        outs_t act;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_start    = 1'($urandom);
            i_band_sel = 3'($urandom);
            cycle(1'($urandom));
            act = observed();
            vectors++;
            if (act !== '0) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d act=%h exp=0", i, act);
            end
        end
        i_start = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_band_sel = 3'($urandom);
            cycle(1'b1);
            act = observed();
            vectors++;
            if (act !== '0) begin
                miscompares++;
                $display("FAIL idle_after_reset i=%0d act=%h exp=0", i, act);
            end
        end
    endtask

    task automatic test_nominal;
        outs_t act, exp;
        i_band_sel = 3'd3;
        i_start    = 1'b1;
        cycle(1'b1);
        i_start = 1'b0;
        for (int n = 0; n <= IDLE_N; n++) begin
            if (n > 0) cycle(1'b1);
            act = observed();
            exp = model(n, 3);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL nominal n=%0d act=%h exp=%h", n, act, exp);
            end
        end
    endtask

    task automatic test_clock_enable;
        outs_t act, exp;
        int n = 0;
        int k = 1;
        i_band_sel = 3'd3;
        i_start    = 1'b1;
        cycle(1'b1);
        i_start = 1'b0;
        while (n < IDLE_N && k < 1000) begin
            cycle(k % 3 == 0);
            if (k % 3 == 0) n++;
            k++;
            act = observed();
            exp = model(n, 3);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL clk_enable k=%0d n=%0d act=%h exp=%h", k, n, act, exp);
            end
        end
        vectors++;
        if (n < IDLE_N) begin
            miscompares++;
            $display("FAIL clk_enable_timeout n=%0d required=%0d", n, IDLE_N);
        end
    endtask

    task automatic test_start_while_busy;
        outs_t act, exp;
        i_band_sel = 3'd3;
        i_start    = 1'b1;
        cycle(1'b1);
        i_start = 1'b0;
        for (int n = 0; n <= IDLE_N + 8; n++) begin
            if (n > 0) cycle(1'b1);
            i_start    = (n == 12);
            i_band_sel = (n == 12) ? 3'd5 : 3'd3;
            act = observed();
            exp = model(n, 3);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL start_busy n=%0d act=%h exp=%h", n, act, exp);
            end
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset_mid;
        outs_t act, exp;
        i_band_sel = 3'd3;
        i_start    = 1'b1;
        cycle(1'b1);
        i_start = 1'b0;
        for (int n = 1; n <= 32; n++) cycle(1'b1);
        #2 rst = 1'b0;
        #1 act = observed();
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL reset_async act=%h exp=0", act);
        end
        for (int i = 0; i < 5; i++) begin
            i_band_sel = 3'($urandom);
            cycle(1'b1);
            act = observed();
            vectors++;
            if (act !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_hold i=%0d act=%h exp=0", i, act);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            act = observed();
            vectors++;
            if (act !== model(-1, 0)) begin
                miscompares++;
                $display("FAIL reset_mid_idle i=%0d act=%h exp=0", i, act);
            end
        end
        i_band_sel = 3'd7;
        i_start    = 1'b1;
        cycle(1'b1);
        i_start = 1'b0;
        for (int n = 0; n <= IDLE_N; n++) begin
            if (n > 0) cycle(1'b1);
            act = observed();
            exp = model(n, 7);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL restart n=%0d act=%h exp=%h", n, act, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        outs_t act, exp;
        int b1 = int'($urandom_range(0, 7));
        int b2 = int'($urandom_range(0, 7));
        int n = 0;
        int k = 0;
        logic en;
        i_band_sel = 3'(b1);
        i_start    = 1'b1;
        cycle(1'b1);
        while (n < 2 * IDLE_N && k < 2000) begin
            i_start    = (n < 2 * LAT + 1);
            i_band_sel = (n == LAT) ? 3'(b2) : 3'($urandom);
            en = ($urandom_range(0, 3) != 0);
            cycle(en);
            if (en) n++;
            k++;
            act = observed();
            exp = (n <= LAT) ? model(n, b1) : model(n - IDLE_N, b2);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL back_to_back n=%0d act=%h exp=%h", n, act, exp);
            end
            if (act.we && act.wd) begin
                miscompares++;
                $display("FAIL we_wd_overlap n=%0d we=%b wd=%b required=no overlap", n, act.we, act.wd);
            end
        end
        vectors++;
        if (n < 2 * IDLE_N) begin
            miscompares++;
            $display("FAIL back_to_back_timeout n=%0d required=%0d", n, 2 * IDLE_N);
        end
        i_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        clk_enable = 1'b0;
        i_start    = 1'b0;
        i_band_sel = '0;
        test_reset();
        test_nominal();
        test_clock_enable();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coeffs_writer.md
Name: coeffs_writer

Overview:
- Master side of the filter's coefficient-load interface: drives write_enable, write_address, coeffs_in and write_done into a band filter.
- On a start request, fetches one band's NUM_TAPS coefficients from an external synchronous coefficient ROM and streams them as back-to-back writes.
- Then holds write_done long enough for the filter's phase-63 capture logic to see it.
- Sits between the equalizer's band-select/control logic and each filter instance.

Parameters:
- NUM_TAPS, 64, coefficients per band; also the write address range.
- ADDR_W, 6, write address width; 2**ADDR_W >= NUM_TAPS.
- COEFF_W, 16, signed coefficient width.
- BAND_W, 3, band select width (8 bands).
- DONE_HOLD, 64, enabled cycles o_write_done stays high; must be >= one full filter counter period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clk_enable  in  1  global clock enable; all state advances only when high
- i_start  in  1  load request, sampled in IDLE only
- i_band_sel  in  BAND_W  band whose coefficients are loaded; latched on accepted start
- o_rom_addr  out  BAND_W+ADDR_W  ROM address {band, tap}
- i_rom_data  in  COEFF_W  ROM read data, valid one enabled cycle after o_rom_addr is registered
- o_write_enable  out  1  to filter i_write_enable
- o_write_address  out  ADDR_W  to filter i_write_address
- o_coeffs_in  out  COEFF_W  to filter i_coeffs_in (signed)
- o_write_done  out  1  to filter i_write_done
- o_busy  out  1  high from accepted start until return to IDLE
- o_done  out  1  one-enabled-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including o_rom_addr; counters 0. Takes effect immediately, including mid-load. The filter sees the partial load without write_done, so no coefficient swap occurs.
- clk_enable low: state, counters and all outputs hold their values. The ROM is gated by the same clk_enable.
- States: IDLE, FETCH, WRITE, HOLD, FIN.
- IDLE: o_busy=0. On an enabled edge with i_start=1:
  - latch band;
  - o_rom_addr={band,0};
  - o_busy=1;
  - go to FETCH.
- FETCH (1 enabled cycle): o_rom_addr increments to tap 1; go to WRITE.
- WRITE: on each enabled edge:
  - o_write_enable=1, o_coeffs_in=i_rom_data, o_write_address=wr_cnt;
  - wr_cnt increments; o_rom_addr tap increments, saturating at NUM_TAPS-1.
  - The first write is registered on the 2nd enabled edge after start.
  - Exactly NUM_TAPS consecutive writes, addresses 0..NUM_TAPS-1 in order.
  - After write NUM_TAPS-1, the next enabled edge goes to HOLD.
- HOLD:
  - o_write_enable=0, o_write_address=0, o_coeffs_in=0, o_write_done=1;
  - hold_cnt counts DONE_HOLD enabled cycles;
  - after the last one, o_write_done=0 and go to FIN.
- FIN: o_done=1 for one enabled cycle, then IDLE with o_busy=0.
- i_start while o_busy=1 is ignored, never queued. Changes to i_band_sel after acceptance are ignored.
- i_start held high continuously: a new load is accepted on the first enabled IDLE cycle after FIN.
- Arithmetic: counters are unsigned. wr_cnt is ADDR_W+1 bits wide so that NUM_TAPS=2**ADDR_W terminates without wrap. hold_cnt is $clog2(DONE_HOLD+1) bits. Coefficients pass through bit-exact, with no sign manipulation.
- Total latency, start to o_done, in enabled cycles: 2 + NUM_TAPS + DONE_HOLD + 1 (default 131).

Test Plan:
- Reset/idle: rst low with random inputs -> all outputs 0. Release, i_start=0 for 20 cycles -> outputs stay 0, o_busy=0.
- Nominal load: ROM word = {band,tap}+0x100, i_band_sel=3, 1-cycle i_start.
  - First write on the 2nd edge after start.
  - 64 contiguous writes, addr 0..63, data 0x1C0..0x1FF.
  - Then o_write_done high exactly 64 cycles; o_done pulses at cycle 131; o_busy falls with it.
- Clock enable: toggle clk_enable in a 1-on/2-off pattern during the load.
  - Same write sequence and values as the nominal load.
  - Every output frozen while clk_enable=0.
  - Completion at 131 enabled cycles.
- Start while busy: pulse i_start with i_band_sel=5 at write 10 -> ignored; band 3 data continues; no second load.
- Reset mid-operation: assert rst during write 30, then restart with band 7.
  - Outputs clear immediately; o_write_done never asserted for the aborted load.
  - Restart yields a full 64-write band-7 sequence from address 0.
- Back-to-back: i_start held high -> second load begins on the enabled cycle after the o_done pulse. No overlap of o_write_done with o_write_enable.
